// File: rtl/ysyx_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_lsu_pkg
//  Description : Shared types for the ysyx load/store unit: access size,
//                error cause, FSM state, and the alignment check helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        C_NONE  = 2'd0,
        C_MISAL = 2'd1,
        C_BUS   = 2'd2,
        C_TMO   = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // An access is legal when the address is a multiple of its size. A dword
    // is additionally illegal on a 32-bit datapath and is reported the same way.
    function automatic logic is_misaligned(input size_e size, input logic [2:0] low,
                                           input logic dword_ok);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = low[0];
            SZ_W:    mis = |low[1:0];
            default: mis = !dword_ok || (|low);
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_lsu_req_if / ysyx_lsu_mem_if
//  Description : EXU-facing request/response bundle and memory-facing
//                valid/ready bundle of the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_lsu_req_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic [1:0]        rsp_cause;

    // EXU side issues requests and consumes results
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cause
    );

    // LSU side accepts requests and produces results
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_cause
    );
endinterface

interface ysyx_lsu_mem_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [XLEN/8-1:0] mem_req_wstrb;
    logic              mem_resp_valid;
    logic              mem_resp_ready;
    logic [XLEN-1:0]   mem_resp_rdata;
    logic              mem_resp_err;

    // LSU side drives requests into memory
    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
               mem_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );

    // Memory side serves requests
    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
               mem_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_lsu_align
//  Description : Combinational byte-lane aligner. LOAD=0: shifts store data
//                into its lane and builds the byte strobe. LOAD=1: extracts
//                the addressed field from a full-width word and extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit LOAD = 1'b0
) (
    input  size_e                       size_i,
    input  logic [$clog2(XLEN/8)-1:0]   off_i,
    input  logic                        sext_i,
    input  logic [XLEN-1:0]             data_i,
    output logic [XLEN-1:0]             data_o,
    output logic [XLEN/8-1:0]           strb_o
);
    localparam int STRB_W = XLEN / 8;

    if (LOAD) begin : g_load
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] field_mask;
        logic            sign_bit;

        // Move the addressed lane to bit 0, keep the access width, then fill
        // the upper bits with the field's sign bit when sign extension applies.
        // Dwords always fill the whole word, so they never sign-extend.
        always_comb begin
            shifted    = data_i >> {off_i, 3'b000};
            field_mask = '0;
            sign_bit   = 1'b0;
            case (size_i)
                SZ_B: begin
                    field_mask = XLEN'(8'hFF);
                    sign_bit   = shifted[7];
                end
                SZ_H: begin
                    field_mask = XLEN'(16'hFFFF);
                    sign_bit   = shifted[15];
                end
                SZ_W: begin
                    field_mask = XLEN'(32'hFFFF_FFFF);
                    sign_bit   = shifted[31];
                end
                default: begin
                    field_mask = '1;
                    sign_bit   = 1'b0;
                end
            endcase
            data_o = (shifted & field_mask) | ((sext_i && sign_bit) ? ~field_mask : '0);
        end

        assign strb_o = '0;
    end else begin : g_store
        logic [STRB_W-1:0] base_strb;
        logic              sext_unused;

        assign sext_unused = sext_i;

        // One strobe bit per byte of the access, shifted to the lane offset;
        // data moves by the same number of bytes.
        always_comb begin
            base_strb = '0;
            case (size_i)
                SZ_B:    base_strb = STRB_W'(8'h01);
                SZ_H:    base_strb = STRB_W'(8'h03);
                SZ_W:    base_strb = STRB_W'(8'h0F);
                default: base_strb = '1;
            endcase
            strb_o = base_strb << off_i;
            data_o = data_i << {off_i, 3'b000};
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_lsu
//  Description : Multi-cycle load/store unit. Accepts one EXU access at a
//                time, checks alignment, issues a valid/ready memory request,
//                waits for the response with an optional timeout and returns
//                extended load data or an error cause.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    ysyx_lsu_req_if.slave   exu,
    ysyx_lsu_mem_if.master  mem
);
    localparam int OFF_W  = $clog2(XLEN / 8);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    size_e               size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                err_q, err_d;
    cause_e              cause_q, cause_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic [OFF_W-1:0]    lane_off;
    logic [XLEN-1:0]     st_data;
    logic [XLEN/8-1:0]   st_strb;
    logic [XLEN-1:0]     ld_data;
    logic [XLEN/8-1:0]   ld_strb_unused;
    logic                in_req;
    logic                in_wait;
    logic                in_resp;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign lane_off = addr_q[OFF_W-1:0];
    assign in_req   = (state_q == S_REQ);
    assign in_wait  = (state_q == S_WAIT);
    assign in_resp  = (state_q == S_RESP);

    ysyx_lsu_align #(
        .XLEN (XLEN),
        .LOAD (1'b0)
    ) u_st_align (
        .size_i (size_q),
        .off_i  (lane_off),
        .sext_i (1'b0),
        .data_i (wdata_q),
        .data_o (st_data),
        .strb_o (st_strb)
    );

    ysyx_lsu_align #(
        .XLEN (XLEN),
        .LOAD (1'b1)
    ) u_ld_align (
        .size_i (size_q),
        .off_i  (lane_off),
        .sext_i (~uns_q),
        .data_i (mem.mem_resp_rdata),
        .data_o (ld_data),
        .strb_o (ld_strb_unused)
    );

    // Next-state logic: request capture, memory handshake, timeout, result hold
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (exu.req_valid) begin
                    we_d    = exu.req_we;
                    size_d  = size_e'(exu.req_size);
                    uns_d   = exu.req_unsigned;
                    addr_d  = exu.req_addr;
                    wdata_d = exu.req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (is_misaligned(size_e'(exu.req_size), exu.req_addr[2:0], XLEN == 64)) begin
                        // Reject without touching memory
                        err_d   = 1'b1;
                        cause_d = C_MISAL;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        cause_d = C_NONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A response presented alongside mem_req_ready is not taken
                // here; memory re-presents it once we are in WAIT.
                if (mem.mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (mem.mem_resp_valid) begin
                    state_d = S_RESP;
                    if (mem.mem_resp_err) begin
                        err_d   = 1'b1;
                        cause_d = C_BUS;
                        rdata_d = '0;
                    end else begin
                        rdata_d = we_q ? '0 : ld_data;
                    end
                end else if (TMO_EN && (cnt_inc == TMO_CNT)) begin
                    err_d   = 1'b1;
                    cause_d = C_TMO;
                    rdata_d = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (exu.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request/result registers, synchronously cleared by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cause_q <= C_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    // EXU side: only one access in flight, result fields qualified by rsp_valid
    assign exu.req_ready = (state_q == S_IDLE);
    assign exu.rsp_valid = in_resp;
    assign exu.rsp_rdata = in_resp ? rdata_q : '0;
    assign exu.rsp_err   = in_resp & err_q;
    assign exu.rsp_cause = in_resp ? cause_q : C_NONE;

    // Memory side: request fields come straight from the captured request
    assign mem.mem_req_valid  = in_req;
    assign mem.mem_req_we     = in_req & we_q;
    assign mem.mem_req_addr   = in_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem.mem_req_wdata  = (in_req & we_q) ? st_data : '0;
    assign mem.mem_req_wstrb  = (in_req & we_q) ? st_strb : '0;
    assign mem.mem_resp_ready = in_wait;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_lsu
//  Description : Directed self-checking bench for ysyx_lsu; one 32-bit build
//                with a short timeout and one 64-bit build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_lsu;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ysyx_lsu_req_if #(.XLEN(32), .ADDR_W(32)) exu32 ();
    ysyx_lsu_mem_if #(.XLEN(32), .ADDR_W(32)) mem32 ();
    ysyx_lsu_req_if #(.XLEN(64), .ADDR_W(32)) exu64 ();
    ysyx_lsu_mem_if #(.XLEN(64), .ADDR_W(32)) mem64 ();

    ysyx_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .exu (exu32),
        .mem (mem32)
    );

    ysyx_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .exu (exu64),
        .mem (mem64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exu32.req_valid = 0; exu32.req_we = 0; exu32.req_size = 0; exu32.req_unsigned = 0;
        exu32.req_addr = 0; exu32.req_wdata = 0; exu32.rsp_ready = 0;
        mem32.mem_req_ready = 0; mem32.mem_resp_valid = 0; mem32.mem_resp_rdata = 0;
        mem32.mem_resp_err = 0;
        exu64.req_valid = 0; exu64.req_we = 0; exu64.req_size = 0; exu64.req_unsigned = 0;
        exu64.req_addr = 0; exu64.req_wdata = 0; exu64.rsp_ready = 0;
        mem64.mem_req_ready = 0; mem64.mem_resp_valid = 0; mem64.mem_resp_rdata = 0;
        mem64.mem_resp_err = 0;
    endtask

    // ---- 32-bit build helpers ----
    task automatic issue32(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        check("req_ready_idle32", exu32.req_ready, 1);
        exu32.req_we = we; exu32.req_size = size; exu32.req_unsigned = uns;
        exu32.req_addr = addr; exu32.req_wdata = wdata; exu32.req_valid = 1;
        tick();
        exu32.req_valid = 0;
    endtask

    task automatic mem_ack32(input logic [31:0] rdata, input logic err);
        mem32.mem_req_ready = 1;
        tick();
        mem32.mem_req_ready  = 0;
        mem32.mem_resp_valid = 1;
        mem32.mem_resp_rdata = rdata;
        mem32.mem_resp_err   = err;
        tick();
        mem32.mem_resp_valid = 0;
        mem32.mem_resp_err   = 0;
    endtask

    task automatic finish32();
        exu32.rsp_ready = 1;
        tick();
        exu32.rsp_ready = 0;
        check("back_to_idle32", {exu32.req_ready, exu32.rsp_valid}, 2'b10);
    endtask

    // ---- 64-bit build helpers ----
    task automatic issue64(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [63:0] wdata);
        exu64.req_we = we; exu64.req_size = size; exu64.req_unsigned = uns;
        exu64.req_addr = addr; exu64.req_wdata = wdata; exu64.req_valid = 1;
        tick();
        exu64.req_valid = 0;
    endtask

    task automatic mem_ack64(input logic [63:0] rdata);
        mem64.mem_req_ready = 1;
        tick();
        mem64.mem_req_ready  = 0;
        mem64.mem_resp_valid = 1;
        mem64.mem_resp_rdata = rdata;
        tick();
        mem64.mem_resp_valid = 0;
    endtask

    task automatic finish64();
        exu64.rsp_ready = 1;
        tick();
        exu64.rsp_ready = 0;
        check("back_to_idle64", {exu64.req_ready, exu64.rsp_valid}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;

        // Reset state
        check("rst_req_ready",  exu32.req_ready, 1);
        check("rst_rsp",        {exu32.rsp_valid, exu32.rsp_err, exu32.rsp_cause}, 0);
        check("rst_rdata",      exu32.rsp_rdata, 0);
        check("rst_mem",        {mem32.mem_req_valid, mem32.mem_req_we, mem32.mem_req_wstrb,
                                 mem32.mem_resp_ready}, 0);
        check("rst_mem_addr",   {mem32.mem_req_addr, mem32.mem_req_wdata}, 0);

        // Store byte at lane 3
        issue32(1, 2'd0, 0, 32'h8000_0003, 32'h0000_00AB);
        check("sb_req_ready",   exu32.req_ready, 0);
        check("sb_valid_we",    {mem32.mem_req_valid, mem32.mem_req_we}, 2'b11);
        check("sb_addr",        mem32.mem_req_addr, 32'h8000_0000);
        check("sb_wstrb",       mem32.mem_req_wstrb, 4'b1000);
        check("sb_wdata",       mem32.mem_req_wdata, 32'hAB00_0000);
        mem_ack32(32'h5555_5555, 0);
        check("sb_rsp",         {exu32.rsp_valid, exu32.rsp_err, exu32.rsp_cause}, 4'b1000);
        check("sb_rdata",       exu32.rsp_rdata, 0);
        finish32();

        // Load half, signed then unsigned
        issue32(0, 2'd1, 0, 32'h8000_0002, 0);
        check("lh_addr_strb",   {mem32.mem_req_addr, mem32.mem_req_wstrb, mem32.mem_req_we},
                                {32'h8000_0000, 4'b0000, 1'b0});
        mem_ack32(32'h8001_1234, 0);
        check("lh_rdata",       exu32.rsp_rdata, 32'hFFFF_8001);
        check("lh_err",         {exu32.rsp_valid, exu32.rsp_err}, 2'b10);
        finish32();
        issue32(0, 2'd1, 1, 32'h8000_0002, 0);
        mem_ack32(32'h8001_1234, 0);
        check("lhu_rdata",      exu32.rsp_rdata, 32'h0000_8001);
        finish32();

        // Misaligned word: result one cycle after acceptance, no memory traffic
        issue32(0, 2'd2, 0, 32'h8000_0006, 0);
        check("misal_rsp",      {exu32.rsp_valid, exu32.rsp_err, exu32.rsp_cause}, 4'b1101);
        check("misal_nomem",    mem32.mem_req_valid, 0);
        exu32.rsp_ready = 1;
        tick();
        exu32.rsp_ready = 0;
        check("misal_nomem2",   mem32.mem_req_valid, 0);

        // Dword on the 32-bit build is rejected as misaligned
        issue32(0, 2'd3, 0, 32'h8000_0008, 0);
        check("d32_rsp",        {exu32.rsp_valid, exu32.rsp_err, exu32.rsp_cause}, 4'b1101);
        finish32();

        // mem_req_ready held low for 5 cycles: request fields stay put
        issue32(1, 2'd1, 0, 32'h8000_0002, 32'h0000_BEEF);
        for (int i = 0; i < 5; i++) begin
            check("stall_addr", {mem32.mem_req_valid, mem32.mem_req_addr}, {1'b1, 32'h8000_0000});
            check("stall_wd",   {mem32.mem_req_wstrb, mem32.mem_req_wdata}, {4'b1100, 32'hBEEF_0000});
            tick();
        end
        mem_ack32(0, 0);
        finish32();

        // rsp_ready held low for 3 cycles: result stays put, no new acceptance
        issue32(0, 2'd2, 0, 32'h8000_0004, 0);
        mem_ack32(32'hCAFE_F00D, 0);
        exu32.req_valid = 1;
        exu32.req_addr  = 32'h8000_0100;
        for (int i = 0; i < 3; i++) begin
            check("rstall_flags", {exu32.rsp_valid, exu32.rsp_err, exu32.rsp_cause, exu32.req_ready},
                                  5'b10000);
            check("rstall_rdata", exu32.rsp_rdata, 32'hCAFE_F00D);
            tick();
        end
        exu32.req_valid = 0;
        finish32();

        // Response presented together with mem_req_ready in REQ is not taken
        issue32(0, 2'd2, 0, 32'h8000_0008, 0);
        mem32.mem_req_ready  = 1;
        mem32.mem_resp_valid = 1;
        mem32.mem_resp_rdata = 32'hDEAD_DEAD;
        tick();
        mem32.mem_req_ready  = 0;
        mem32.mem_resp_rdata = 32'h1122_3344;
        check("early_resp_ignored", {exu32.rsp_valid, mem32.mem_resp_ready}, 2'b01);
        tick();
        mem32.mem_resp_valid = 0;
        check("early_resp_data", exu32.rsp_rdata, 32'h1122_3344);
        finish32();

        // Timeout after 4 WAIT cycles, late response ignored
        issue32(0, 2'd2, 0, 32'h8000_0010, 0);
        mem32.mem_req_ready = 1;
        tick();
        mem32.mem_req_ready = 0;
        tick(); tick(); tick();
        check("tmo_still_wait", {exu32.rsp_valid, mem32.mem_resp_ready}, 2'b01);
        tick();
        check("tmo_rsp",        {exu32.rsp_valid, exu32.rsp_err, exu32.rsp_cause}, 4'b1111);
        check("tmo_rdata",      exu32.rsp_rdata, 0);
        mem32.mem_resp_valid = 1;
        mem32.mem_resp_rdata = 32'h7777_7777;
        #1;
        check("late_not_ready", mem32.mem_resp_ready, 0);
        finish32();
        mem32.mem_resp_valid = 0;
        issue32(0, 2'd0, 1, 32'h8000_0001, 0);
        mem_ack32(32'h0000_5A00, 0);
        check("after_tmo",      {exu32.rsp_err, exu32.rsp_cause, exu32.rsp_rdata},
                                {1'b0, 2'd0, 32'h0000_005A});
        finish32();

        // Bus error on a load
        issue32(0, 2'd2, 0, 32'h8000_0020, 0);
        mem_ack32(32'h1234_5678, 1);
        check("bus_rsp",        {exu32.rsp_valid, exu32.rsp_err, exu32.rsp_cause}, 4'b1110);
        check("bus_rdata",      exu32.rsp_rdata, 0);
        finish32();

        // Reset while waiting for memory
        issue32(0, 2'd2, 0, 32'h8000_0030, 0);
        mem32.mem_req_ready = 1;
        tick();
        mem32.mem_req_ready = 0;
        check("rst_pre_wait",   mem32.mem_resp_ready, 1);
        rst = 1;
        tick();
        rst = 0;
        check("rst_wait_idle",  {exu32.req_ready, exu32.rsp_valid, mem32.mem_resp_ready}, 3'b100);

        // 64-bit build
        issue64(0, 2'd3, 0, 32'h8000_0008, 0);
        check("ld64_addr",      {mem64.mem_req_valid, mem64.mem_req_addr}, {1'b1, 32'h8000_0008});
        mem_ack64(64'hFEDC_BA98_7654_3210);
        check("ld64_rdata",     exu64.rsp_rdata, 64'hFEDC_BA98_7654_3210);
        finish64();
        issue64(0, 2'd2, 0, 32'h8000_000C, 0);
        mem_ack64(64'h8000_0000_0000_0000);
        check("lw64_sext",      exu64.rsp_rdata, 64'hFFFF_FFFF_8000_0000);
        finish64();
        issue64(1, 2'd2, 0, 32'h8000_0004, 64'h0000_0000_1122_3344);
        check("sw64_addr",      mem64.mem_req_addr, 32'h8000_0000);
        check("sw64_wstrb",     mem64.mem_req_wstrb, 8'hF0);
        check("sw64_wdata",     mem64.mem_req_wdata, 64'h1122_3344_0000_0000);
        mem_ack64(0);
        finish64();
        issue64(0, 2'd3, 0, 32'h8000_0004, 0);
        check("misal64",        {exu64.rsp_valid, exu64.rsp_err, exu64.rsp_cause, mem64.mem_req_valid},
                                5'b11010);
        finish64();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
